// File: rtl/tdm_demux4.sv
// tdm_demux4 - receive end of a 4-slot TDM link.
// Finds frame alignment from the slot-0 sync marker, steers slots a..c into
// shadow registers, then publishes a..d together on the edge that takes the
// slot-3 beat, so the outputs only ever show one complete frame.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   din[W]       slot sample, used only when en=1
//   en           beat strobe (din/sync valid)
//   sync         marks the beat as slot 0
//   a..d_out[W]  channels of the last complete frame
//   frame_valid  1-cycle pulse when a..d_out update
//   sync_err     1-cycle pulse on a framing violation
//   locked       high while aligned to the frame
//
// state  | meaning
// HUNT   | waiting for a sync beat; non-sync beats are dropped
// LOCKED | aligned; slot counts 0..3 through the current frame
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         sync,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic [W-1:0] c_out,
  output logic [W-1:0] d_out,
  output logic         frame_valid,
  output logic         sync_err,
  output logic         locked
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t       state;
  logic [1:0]   slot;
  logic [W-1:0] shadow_a;
  logic [W-1:0] shadow_b;
  logic [W-1:0] shadow_c;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      shadow_a    <= '0;
      shadow_b    <= '0;
      shadow_c    <= '0;
      a_out       <= '0;
      b_out       <= '0;
      c_out       <= '0;
      d_out       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (sync) begin
              shadow_a <= din;
              slot     <= 2'd1;
              state    <= LOCKED;
            end
          end
          LOCKED: begin
            if (slot == 2'd0) begin
              if (sync) begin
                shadow_a <= din;
                slot     <= 2'd1;
              end else begin
                sync_err <= 1'b1;
                slot     <= 2'd0;
                state    <= HUNT;
              end
            end else if (sync) begin
              // Early sync: abandon the partial frame and restart on this beat.
              sync_err <= 1'b1;
              shadow_a <= din;
              slot     <= 2'd1;
            end else begin
              case (slot)
                2'd1: shadow_b <= din;
                2'd2: shadow_c <= din;
                default: begin
                  a_out       <= shadow_a;
                  b_out       <= shadow_b;
                  c_out       <= shadow_c;
                  d_out       <= din;
                  frame_valid <= 1'b1;
                end
              endcase
              slot <= slot + 2'd1;  // 3 wraps to 0
            end
          end
          default: begin
            state <= HUNT;
            slot  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 - directed bench for tdm_demux4 (W=4).
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge that produced them.
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         en;
  logic         sync;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic [W-1:0] c_out;
  logic [W-1:0] d_out;
  logic         frame_valid;
  logic         sync_err;
  logic         locked;

  int n_chk = 0;
  int n_err = 0;

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .en          (en),
    .sync        (sync),
    .a_out       (a_out),
    .b_out       (b_out),
    .c_out       (c_out),
    .d_out       (d_out),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic [W-1:0] ec, input logic [W-1:0] ed);
    chk({tag, ".a"}, 32'(a_out), 32'(ea));
    chk({tag, ".b"}, 32'(b_out), 32'(eb));
    chk({tag, ".c"}, 32'(c_out), 32'(ec));
    chk({tag, ".d"}, 32'(d_out), 32'(ed));
  endtask

  task automatic beat(input string tag, input logic s, input logic [W-1:0] d,
                      input logic exp_fv, input logic exp_se);
    @(negedge clk);
    en   = 1'b1;
    sync = s;
    din  = d;
    @(posedge clk);
    #1;
    chk({tag, ".fv"}, 32'(frame_valid), 32'(exp_fv));
    chk({tag, ".se"}, 32'(sync_err), 32'(exp_se));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en   = 1'b0;
      sync = 1'($urandom);
      din  = W'($urandom);
      @(posedge clk);
      #1;
      chk({tag, ".idle_fv"}, 32'(frame_valid), 32'd0);
      chk({tag, ".idle_se"}, 32'(sync_err), 32'd0);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst  = 1'b1;
      en   = 1'($urandom);
      sync = 1'($urandom);
      din  = W'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    sync = 1'b0;
    din  = '0;

    // T1 reset
    do_reset(2);
    #1;
    chk_out("t1", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("t1.fv", 32'(frame_valid), 32'd0);
    chk("t1.se", 32'(sync_err), 32'd0);
    chk("t1.locked", 32'(locked), 32'd0);

    // T2 back-to-back frame 1,0,1,1
    beat("t2.b0", 1'b1, 4'h1, 1'b0, 1'b0);
    chk("t2.locked", 32'(locked), 32'd1);
    beat("t2.b1", 1'b0, 4'h0, 1'b0, 1'b0);
    beat("t2.b2", 1'b0, 4'h1, 1'b0, 1'b0);
    beat("t2.b3", 1'b0, 4'h1, 1'b1, 1'b0);
    chk_out("t2", 4'h1, 4'h0, 4'h1, 4'h1);
    idle("t2", 1);
    chk_out("t2.hold", 4'h1, 4'h0, 4'h1, 4'h1);

    // T3 same frame with 3-cycle gaps, from a cleared state
    do_reset(1);
    beat("t3.b0", 1'b1, 4'h1, 1'b0, 1'b0);
    idle("t3.g0", 3);
    beat("t3.b1", 1'b0, 4'h0, 1'b0, 1'b0);
    idle("t3.g1", 3);
    beat("t3.b2", 1'b0, 4'h1, 1'b0, 1'b0);
    idle("t3.g2", 3);
    chk_out("t3.pre", 4'h0, 4'h0, 4'h0, 4'h0);
    beat("t3.b3", 1'b0, 4'h1, 1'b1, 1'b0);
    chk_out("t3", 4'h1, 4'h0, 4'h1, 4'h1);
    idle("t3", 1);

    // T4 premature sync in frame 2
    beat("t4.f1b0", 1'b1, 4'h1, 1'b0, 1'b0);
    beat("t4.f1b1", 1'b0, 4'h1, 1'b0, 1'b0);
    beat("t4.f1b2", 1'b0, 4'h1, 1'b0, 1'b0);
    beat("t4.f1b3", 1'b0, 4'h1, 1'b1, 1'b0);
    chk_out("t4.f1", 4'h1, 4'h1, 4'h1, 4'h1);
    beat("t4.f2b0", 1'b1, 4'h0, 1'b0, 1'b0);
    beat("t4.f2b1", 1'b0, 4'h0, 1'b0, 1'b0);
    beat("t4.early", 1'b1, 4'h1, 1'b0, 1'b1);
    chk_out("t4.held", 4'h1, 4'h1, 4'h1, 4'h1);
    chk("t4.locked", 32'(locked), 32'd1);
    beat("t4.n1", 1'b0, 4'h0, 1'b0, 1'b0);
    beat("t4.n2", 1'b0, 4'h1, 1'b0, 1'b0);
    chk_out("t4.mid", 4'h1, 4'h1, 4'h1, 4'h1);
    beat("t4.n3", 1'b0, 4'h0, 1'b1, 1'b0);
    chk_out("t4.new", 4'h1, 4'h0, 4'h1, 4'h0);

    // T5 missing sync at slot 0, then relock
    beat("t5.miss", 1'b0, 4'h1, 1'b0, 1'b1);
    chk("t5.unlocked", 32'(locked), 32'd0);
    chk_out("t5.held", 4'h1, 4'h0, 4'h1, 4'h0);
    beat("t5.relock", 1'b1, 4'h0, 1'b0, 1'b0);
    chk("t5.locked", 32'(locked), 32'd1);
    beat("t5.b1", 1'b0, 4'h1, 1'b0, 1'b0);
    beat("t5.b2", 1'b0, 4'h1, 1'b0, 1'b0);
    beat("t5.b3", 1'b0, 4'h1, 1'b1, 1'b0);
    chk_out("t5", 4'h0, 4'h1, 4'h1, 4'h1);

    // T6 reset mid-frame, then a full W=4 frame
    beat("t6.p0", 1'b1, 4'hF, 1'b0, 1'b0);
    beat("t6.p1", 1'b0, 4'hF, 1'b0, 1'b0);
    do_reset(1);
    #1;
    chk("t6.rst_locked", 32'(locked), 32'd0);
    chk_out("t6.rst", 4'h0, 4'h0, 4'h0, 4'h0);
    beat("t6.drop", 1'b0, 4'h9, 1'b0, 1'b0);
    chk("t6.hunt", 32'(locked), 32'd0);
    beat("t6.b0", 1'b1, 4'h3, 1'b0, 1'b0);
    beat("t6.b1", 1'b0, 4'hA, 1'b0, 1'b0);
    beat("t6.b2", 1'b0, 4'h5, 1'b0, 1'b0);
    beat("t6.b3", 1'b0, 4'hC, 1'b1, 1'b0);
    chk_out("t6", 4'h3, 4'hA, 4'h5, 4'hC);
    idle("t6", 2);
    chk_out("t6.hold", 4'h3, 4'hA, 4'h5, 4'hC);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
